// File: rtl/alu_cmd_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_if
// Bundles every signal between alu_cmd_ctrl and its neighbours: the receive
// byte stream, the ALU operand/result path and the transmit handshake.
//   master : the controller side (drives ALU operands and TX, gets RX/result)
//   slave  : the environment side (RX source, ALU, serializer)
// Signals:
//   rx_p_data/rx_d_vld : received byte and its one-cycle strobe
//   alu_out/out_valid  : ALU registered result and sticky valid
//   tx_busy            : serializer busy, a byte is accepted only when low
//   alu_a/alu_b/alu_fun/alu_en : ALU operands, function code, enable pulse
//   tx_p_data/tx_d_vld : byte to serializer and its one-cycle strobe
//   frame_err          : one-cycle error pulse
// ---------------------------------------------------------------------------
interface alu_cmd_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   rx_p_data;
  logic                    rx_d_vld;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    out_valid;
  logic                    tx_busy;
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [3:0]              alu_fun;
  logic                    alu_en;
  logic [DATA_WIDTH-1:0]   tx_p_data;
  logic                    tx_d_vld;
  logic                    frame_err;

  modport master (
    input  rx_p_data, rx_d_vld, alu_out, out_valid, tx_busy,
    output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, frame_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, alu_out, out_valid, tx_busy,
    input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, frame_err
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// alu_cmd_ctrl
// Assembles ALU command frames from a received byte stream, fires the ALU,
// captures its 16-bit result and returns it LSB first to a serializer.
//   0xCC, A, B, FUN : load both operands and the function code, execute
//   0xDD, FUN       : reuse the held operands, load the function code, execute
// Malformed frames, stray bytes and inter-byte timeouts raise a one-cycle
// frame_err pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_cmd_if.master (RX stream, ALU path, TX handshake, frame_err)
// All outputs are registered.
// ---------------------------------------------------------------------------
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_cmd_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_LOAD  = DATA_WIDTH'('hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'('hDD);
  // The registered error lands on the edge where the count would hit
  // TIMEOUT_CYC, i.e. exactly TIMEOUT_CYC idle cycles after the last byte.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_EXEC, ALU_WAIT,
    TX_LSB, TX_LSB_G, TX_MSB, TX_MSB_G
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    err_q, err_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic fun_bad;
  logic expire;
  logic busy_phase;

  assign fun_bad    = |bus.rx_p_data[DATA_WIDTH-1:4];
  assign expire     = !bus.rx_d_vld && (cnt_q == CNT_LAST);
  assign busy_phase = (state_q == ALU_EXEC) || (state_q == ALU_WAIT) ||
                      (state_q == TX_LSB)   || (state_q == TX_LSB_G) ||
                      (state_q == TX_MSB)   || (state_q == TX_MSB_G);

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    alu_en_d  = 1'b0;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    err_d     = 1'b0;
    result_d  = result_q;
    cnt_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_d_vld) begin
          if (bus.rx_p_data == CMD_LOAD)       state_d = GET_A;
          else if (bus.rx_p_data == CMD_REUSE) state_d = GET_FUN;
          else                                 err_d   = 1'b1;
        end
      end
      GET_A: begin
        if (bus.rx_d_vld) begin
          alu_a_d = bus.rx_p_data;
          state_d = GET_B;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GET_B: begin
        if (bus.rx_d_vld) begin
          alu_b_d = bus.rx_p_data;
          state_d = GET_FUN;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GET_FUN: begin
        if (bus.rx_d_vld) begin
          if (fun_bad) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            alu_fun_d = bus.rx_p_data[3:0];
            alu_en_d  = 1'b1;   // high for the single ALU_EXEC cycle
            state_d   = ALU_EXEC;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ALU_EXEC: state_d = ALU_WAIT;
      ALU_WAIT: begin
        // out_valid is sticky in the ALU, so a level check is sufficient.
        if (bus.out_valid) begin
          result_d = bus.alu_out;
          state_d  = TX_LSB;
          // Launch the LSB strobe on the capture edge when the serializer
          // is free, so it is visible during the first TX_LSB cycle.
          if (!bus.tx_busy) begin
            tx_data_d = bus.alu_out[DATA_WIDTH-1:0];
            tx_vld_d  = 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_LSB: begin
        if (tx_vld_q) begin
          state_d = TX_LSB_G;
        end else if (!bus.tx_busy) begin
          tx_data_d = result_q[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
        end
      end
      TX_LSB_G: begin
        // Busy is first examined one cycle after the strobe, giving the
        // serializer a cycle to raise it.
        if (!bus.tx_busy) begin
          tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_d  = 1'b1;
          state_d   = TX_MSB;
        end
      end
      TX_MSB: begin
        if (tx_vld_q) begin
          state_d = TX_MSB_G;
        end else if (!bus.tx_busy) begin
          tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_d  = 1'b1;
        end
      end
      TX_MSB_G: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bytes arriving while a command is in flight are dropped and flagged.
    if (bus.rx_d_vld && busy_phase) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fun   = alu_fun_q;
  assign bus.alu_en    = alu_en_q;
  assign bus.tx_p_data = tx_data_q;
  assign bus.tx_d_vld  = tx_vld_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_ctrl
// Drives byte frames into alu_cmd_ctrl, models the ALU and the serializer,
// and compares responses, pulses and register contents against a frame-level
// reference model.
// ---------------------------------------------------------------------------
module tb_alu_cmd_ctrl;
  localparam int DW = 8;
  localparam int T  = 1023;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_if #(.DATA_WIDTH(DW)) bus ();

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYC(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_n = 0;
  int err_n = 0;

  // Edge counter: an output changed at edge k is seen at the negedge with e==k.
  int e = 0;
  always @(posedge clk) e++;

  // Environment controls.
  logic busy_force = 1'b0;
  logic ser_en     = 1'b0;
  logic alu_dead   = 1'b0;
  logic ser_busy   = 1'b0;
  int   ser_cnt    = 0;

  // Reference ALU, also used by the environment ALU model.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      4'd3:    return {8'h00, a & b};
      4'd4:    return {8'h00, a | b};
      4'd5:    return {8'h00, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  // ALU: registers on alu_en, valid stays high once set.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out   <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.alu_en && !alu_dead) begin
      bus.alu_out   <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_fun);
      bus.out_valid <= 1'b1;
    end
  end

  assign bus.tx_busy = busy_force | ser_busy;

  // Monitor and serializer.
  int          tx_n = 0, en_n = 0, er_n = 0, wide_n = 0;
  int          tx_edge [512];
  logic [7:0]  tx_log  [512];
  int          en_edge = -1, er_edge = -1;
  logic [7:0]  en_a, en_b;
  logic [3:0]  en_f;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_d_vld && tx_n < 512) begin
      tx_log[tx_n]  = bus.tx_p_data;
      tx_edge[tx_n] = e;
      tx_n++;
    end
    if (bus.alu_en) begin
      en_n++;
      en_edge = e;
      en_a = bus.alu_a;
      en_b = bus.alu_b;
      en_f = bus.alu_fun;
    end
    if (bus.frame_err) begin
      er_n++;
      er_edge = e;
      if (prev_err) wide_n++;
    end
    prev_err = bus.frame_err;
    if (ser_cnt > 0) ser_cnt--;
    if (ser_en && bus.tx_d_vld) ser_cnt = $urandom_range(4, 1);
    ser_busy = (ser_cnt != 0);
  end

  // Frame-level model state.
  logic [7:0] ma = 8'h00, mb = 8'h00;
  logic [3:0] mfun = 4'h0;
  int         last_rx_edge = 0;

  task automatic send_byte(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    last_rx_edge  = e + 1;
    @(negedge clk);
    bus.rx_d_vld  = 1'b0;
  endtask

  // Sends one frame, predicts its outcome from the frame rules and checks it.
  task automatic run_frame(input int n, input logic [7:0] fr [4],
                           input int gap_lo, input int gap_hi, input string tag);
    int tx0, en0, er0, exp_tx, exp_en, exp_er, c;
    logic [7:0] f;
    logic [15:0] r;
    logic [7:0] eb [2];
    tx0 = tx_n; en0 = en_n; er0 = er_n;
    exp_tx = 0; exp_en = 0; exp_er = 0;
    eb[0] = 8'h00; eb[1] = 8'h00;
    if (fr[0] == 8'hCC || fr[0] == 8'hDD) begin
      if (fr[0] == 8'hCC) begin
        ma = fr[1]; mb = fr[2]; f = fr[3];
      end else begin
        f = fr[1];
      end
      if (f[7:4] != 4'h0) begin
        exp_er = 1;
      end else begin
        mfun = f[3:0];
        r = alu_ref(ma, mb, mfun);
        eb[0] = r[7:0];
        eb[1] = r[15:8];
        exp_en = 1;
        exp_tx = 2;
      end
    end else begin
      exp_er = 1;
    end

    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
      send_byte(fr[i]);
    end
    c = 0;
    while ((tx_n - tx0) < exp_tx && c < 60) begin
      @(negedge clk); #1;
      c++;
    end
    repeat (8) @(negedge clk);
    #1;

    chk_n++;
    if ((tx_n - tx0) !== exp_tx) begin
      err_n++;
      $display("FAIL %s tx_count: got %0d want %0d", tag, tx_n - tx0, exp_tx);
    end
    for (int i = 0; i < exp_tx && i < (tx_n - tx0); i++) begin
      chk_n++;
      if (tx_log[tx0+i] !== eb[i]) begin
        err_n++;
        $display("FAIL %s tx_byte%0d: got %02h want %02h", tag, i, tx_log[tx0+i], eb[i]);
      end
    end
    if (exp_tx == 2 && (tx_n - tx0) >= 2) begin
      chk_n++;
      if ((tx_edge[tx0+1] - tx_edge[tx0]) < 2) begin
        err_n++;
        $display("FAIL %s tx_spacing: got %0d want >=2", tag, tx_edge[tx0+1] - tx_edge[tx0]);
      end
    end
    chk_n++;
    if ((en_n - en0) !== exp_en) begin
      err_n++;
      $display("FAIL %s alu_en_count: got %0d want %0d", tag, en_n - en0, exp_en);
    end
    if (exp_en == 1 && (en_n - en0) == 1) begin
      chk_n++;
      if ({en_a, en_b, en_f} !== {ma, mb, mfun}) begin
        err_n++;
        $display("FAIL %s exec_operands: got %02h %02h %0h want %02h %02h %0h",
                 tag, en_a, en_b, en_f, ma, mb, mfun);
      end
    end
    chk_n++;
    if ((er_n - er0) !== exp_er) begin
      err_n++;
      $display("FAIL %s frame_err_count: got %0d want %0d", tag, er_n - er0, exp_er);
    end
    chk_n++;
    if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {ma, mb, mfun}) begin
      err_n++;
      $display("FAIL %s regs: got %02h %02h %0h want %02h %02h %0h",
               tag, bus.alu_a, bus.alu_b, bus.alu_fun, ma, mb, mfun);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk_n++;
    if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_p_data,
         bus.tx_d_vld, bus.frame_err} !== 31'd0) begin
      err_n++;
      $display("FAIL %s outputs: got a=%02h b=%02h fun=%0h en=%b txd=%02h txv=%b err=%b want all 0",
               tag, bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_p_data,
               bus.tx_d_vld, bus.frame_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_p_data = '0;
    bus.rx_d_vld  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("post_reset_idle");
  endtask

  // ALU never reports valid: the controller must abort at capture time.
  task automatic test_no_valid();
    int en0, er0, tx0, fun_edge;
    alu_dead = 1'b1;
    en0 = en_n; er0 = er_n; tx0 = tx_n;
    send_byte(8'hDD);
    send_byte(8'h00);
    fun_edge = last_rx_edge;
    mfun = 4'h0;
    repeat (10) @(negedge clk);
    #1;
    chk_n++;
    if ((en_n - en0) !== 1 || (er_n - er0) !== 1 || (tx_n - tx0) !== 0) begin
      err_n++;
      $display("FAIL no_valid counts: got en=%0d err=%0d tx=%0d want 1 1 0",
               en_n - en0, er_n - er0, tx_n - tx0);
    end
    chk_n++;
    if (er_edge !== fun_edge + 2) begin
      err_n++;
      $display("FAIL no_valid err_edge: got %0d want %0d", er_edge, fun_edge + 2);
    end
    alu_dead = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] fr [4];
    int tx0;
    tx0 = tx_n;
    fr = '{8'hCC, 8'h12, 8'h34, 8'h00};
    run_frame(4, fr, 0, 0, "add");
    chk_n++;
    if (en_edge !== last_rx_edge) begin
      err_n++;
      $display("FAIL add en_latency: got edge %0d want %0d", en_edge, last_rx_edge);
    end
    chk_n++;
    if (tx_n > tx0 && tx_edge[tx0] !== last_rx_edge + 2) begin
      err_n++;
      $display("FAIL add tx_latency: got edge %0d want %0d", tx_edge[tx0], last_rx_edge + 2);
    end
  endtask

  task automatic test_reuse();
    logic [7:0] fr [4];
    fr = '{8'hCC, 8'hFF, 8'hFF, 8'h02};
    run_frame(4, fr, 0, 2, "mul_ff");
    fr = '{8'hDD, 8'h01, 8'h00, 8'h00};
    run_frame(2, fr, 0, 2, "reuse_sub");
  endtask

  task automatic test_bad_frames();
    logic [7:0] fr [4];
    fr = '{8'h55, 8'h00, 8'h00, 8'h00};
    run_frame(1, fr, 0, 0, "unknown_cmd");
    fr = '{8'hCC, 8'h01, 8'h02, 8'h13};
    run_frame(4, fr, 0, 0, "bad_fun");
  endtask

  task automatic test_timeout();
    logic [7:0] fr [4];
    int er0, c;
    er0 = er_n;
    send_byte(8'hCC);
    send_byte(8'h05);
    ma = 8'h05;
    c = 0;
    while (er_n == er0 && c < T + 20) begin
      @(negedge clk); #1;
      c++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk_n++;
    if ((er_n - er0) !== 1) begin
      err_n++;
      $display("FAIL timeout err_count: got %0d want 1", er_n - er0);
    end
    chk_n++;
    if (er_edge !== last_rx_edge + T) begin
      err_n++;
      $display("FAIL timeout err_edge: got %0d want %0d", er_edge, last_rx_edge + T);
    end
    chk_n++;
    if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {ma, mb, mfun}) begin
      err_n++;
      $display("FAIL timeout regs: got %02h %02h %0h want %02h %02h %0h",
               bus.alu_a, bus.alu_b, bus.alu_fun, ma, mb, mfun);
    end
    // Longest legal gap: the byte lands on the edge where expiry would fire.
    fr = '{8'hCC, 8'h21, 8'h07, 8'h00};
    run_frame(4, fr, T - 1, T - 1, "gap_limit");
  endtask

  task automatic test_busy_hold();
    int tx0, er0, en0, c, fall_e;
    logic [15:0] r;
    ser_en = 1'b0;
    tx0 = tx_n; er0 = er_n; en0 = en_n;
    send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h03); send_byte(8'h02);
    ma = 8'h0F; mb = 8'h03; mfun = 4'h2;
    r = alu_ref(ma, mb, mfun);
    c = 0;
    while (tx_n == tx0 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    busy_force = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h77);
    repeat (11) @(negedge clk);
    fall_e = e;
    busy_force = 1'b0;
    c = 0;
    while (tx_n < tx0 + 2 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    repeat (6) @(negedge clk);
    #1;
    chk_n++;
    if ((tx_n - tx0) !== 2) begin
      err_n++;
      $display("FAIL busy tx_count: got %0d want 2", tx_n - tx0);
    end else begin
      chk_n++;
      if ({tx_log[tx0], tx_log[tx0+1]} !== {r[7:0], r[15:8]}) begin
        err_n++;
        $display("FAIL busy tx_bytes: got %02h %02h want %02h %02h",
                 tx_log[tx0], tx_log[tx0+1], r[7:0], r[15:8]);
      end
      chk_n++;
      if (tx_edge[tx0+1] <= fall_e) begin
        err_n++;
        $display("FAIL busy msb_edge: got %0d want > %0d", tx_edge[tx0+1], fall_e);
      end
    end
    chk_n++;
    if ((er_n - er0) !== 1 || (en_n - en0) !== 1) begin
      err_n++;
      $display("FAIL busy counts: got err=%0d en=%0d want 1 1", er_n - er0, en_n - en0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr [4];
    int tx0, c;
    tx0 = tx_n;
    send_byte(8'hCC); send_byte(8'h44); send_byte(8'h11); send_byte(8'h00);
    c = 0;
    while (tx_n == tx0 && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    repeat (2) @(negedge clk);
    busy_force = 1'b0;
    rst_n = 1'b1;
    ma = 8'h00; mb = 8'h00; mfun = 4'h0;
    repeat (20) @(negedge clk);
    #1;
    chk_n++;
    if ((tx_n - tx0) !== 1) begin
      err_n++;
      $display("FAIL reset_mid tx_count: got %0d want 1", tx_n - tx0);
    end
    fr = '{8'hCC, 8'h21, 8'h10, 8'h01};
    run_frame(4, fr, 0, 1, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] fr [4];
    int n, kind;
    ser_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(99, 0);
      for (int i = 0; i < 4; i++) fr[i] = 8'($urandom);
      for (int i = 1; i < 4; i++)
        if ($urandom_range(99, 0) < 85) fr[i][7:4] = 4'h0;
      if (kind < 50) begin
        fr[0] = 8'hCC; n = 4;
        fr[3][3:0] = 4'($urandom_range(6, 0));
      end else if (kind < 85) begin
        fr[0] = 8'hDD; n = 2;
        fr[1][3:0] = 4'($urandom_range(6, 0));
      end else begin
        while (fr[0] == 8'hCC || fr[0] == 8'hDD) fr[0] = 8'($urandom);
        n = 1;
      end
      run_frame(n, fr, 0, 3, $sformatf("rand%0d", k));
    end
    ser_en = 1'b0;
  endtask

  task automatic test_pulse_width();
    chk_n++;
    if (wide_n !== 0) begin
      err_n++;
      $display("FAIL err_pulse_width: got %0d wide pulses want 0", wide_n);
    end
  endtask

  initial begin
    test_reset();
    test_no_valid();
    test_add();
    test_reuse();
    test_bad_frames();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_random();
    test_pulse_width();
    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Byte-stream command controller sitting directly upstream of the ALU. It assembles ALU command frames from a received-byte stream and drives the ALU operands, function code and enable. It captures the 16-bit ALU result one cycle later and returns it as two bytes, LSB first, to a downstream serializer over a busy/valid handshake. A per-frame inter-byte timeout and malformed-frame detection keep the pipeline from hanging on a broken link.

## Interface
- DATA_WIDTH, 8, byte/operand width; ALU result width is 2*DATA_WIDTH
- TIMEOUT_CYC, 1023, max idle cycles between bytes of one frame before abort; counter width = clog2(TIMEOUT_CYC+1)
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- RX_P_DATA  input  DATA_WIDTH  received byte, valid when RX_D_VLD=1
- RX_D_VLD  input  1  one-cycle strobe per received byte
- ALU_OUT  input  2*DATA_WIDTH  ALU registered result
- OUT_VALID  input  1  ALU registered valid
- TX_BUSY  input  1  serializer busy; byte accepted only when 0
- ALU_A, ALU_B  output  DATA_WIDTH each  operand registers
- ALU_FUN  output  4  function code register
- ALU_EN  output  1  one-cycle ALU enable pulse
- TX_P_DATA  output  DATA_WIDTH  byte to serializer
- TX_D_VLD  output  1  one-cycle transmit strobe
- FRAME_ERR  output  1  one-cycle error pulse

## Operation
- Frames, first byte is the command:
  - 0xCC, A, B, FUN: load ALU_A, ALU_B, ALU_FUN, then execute.
  - 0xDD, FUN: keep the last ALU_A/ALU_B, load ALU_FUN, then execute.
- FUN byte: bits[3:0] are the code. If bits[7:4] != 0, pulse FRAME_ERR, go to IDLE, do not execute, and leave ALU_FUN unchanged.
- Unknown command byte in IDLE: pulse FRAME_ERR and stay in IDLE.
- FSM states: IDLE, GET_A, GET_B, GET_FUN, ALU_EXEC, ALU_WAIT, TX_LSB, TX_LSB_G, TX_MSB, TX_MSB_G.
  - IDLE -> GET_A on 0xCC; IDLE -> GET_FUN on 0xDD.
  - GET_A -> GET_B -> GET_FUN, each on RX_D_VLD.
  - GET_FUN -> ALU_EXEC on a valid FUN byte.
  - ALU_EXEC: ALU_EN=1 for exactly this one cycle, then -> ALU_WAIT.
  - ALU_WAIT: capture ALU_OUT into an internal result register and go to TX_LSB.
    - This requires OUT_VALID=1; OUT_VALID is sticky in the ALU, so this is a level check, not an edge check.
    - If OUT_VALID=0, pulse FRAME_ERR and go to IDLE.
  - TX_LSB: when TX_BUSY=0, drive TX_P_DATA=result[7:0] with TX_D_VLD=1 for one cycle, then -> TX_LSB_G.
  - TX_LSB_G: one guard cycle with TX_BUSY ignored, then wait until TX_BUSY=0 -> TX_MSB.
  - TX_MSB / TX_MSB_G: same as the LSB pair with result[15:8], then -> IDLE.
- Timeout:
  - The counter clears on every accepted byte and on entry to GET_* states, and counts each cycle in GET_A/GET_B/GET_FUN with no RX_D_VLD.
  - When it reaches TIMEOUT_CYC: FRAME_ERR pulse, go to IDLE, operand/FUN registers unchanged.
  - The counter is inactive outside GET_* states.
- RX_D_VLD in ALU_EXEC..TX_MSB_G: byte dropped, FRAME_ERR pulse, FSM unaffected.
- Operand registers load on byte acceptance and hold between frames.
- ALU_A/ALU_B change only in GET_A/GET_B, so they are stable through ALU_EXEC.
- RX_D_VLD and timeout expiry in the same cycle: the byte wins and the counter clears.

## Timing
- Reset values: ALU_A=0, ALU_B=0, ALU_FUN=0, ALU_EN=0, TX_P_DATA=0, TX_D_VLD=0, FRAME_ERR=0. State = IDLE, result=0, counter=0.
- All outputs are registered.
- Reset mid-frame or mid-transmit aborts immediately; no further TX_D_VLD is issued.
- Latency, with the FUN byte sampled at edge 0:
  - ALU_EN high during cycle 0..1.
  - ALU registers at edge 1.
  - Controller captures at edge 2.
  - First TX_D_VLD in cycle 2..3 if TX_BUSY=0.
- The serializer must raise TX_BUSY no later than the cycle after TX_D_VLD; the guard cycle covers that gap.
- Minimum spacing between the LSB and MSB strobes: 2 cycles.
- FRAME_ERR is always exactly 1 cycle wide. Back-to-back errors give back-to-back pulses.
- Consecutive frames: a new command byte is accepted from IDLE on the cycle after TX_MSB_G exits.

## Test plan
- CC,0x12,0x34,0x00 with TX_BUSY=0 -> one ALU_EN pulse with A=0x12, B=0x34, FUN=0; TX bytes 0x46 then 0x00; FRAME_ERR never pulses.
- CC,0xFF,0xFF,0x02, then DD,0x01 -> first response 0x01,0xFE (0xFE01); second response 0x00,0x00 with ALU_FUN=1 and operands still 0xFF.
- 0x55 in IDLE -> FRAME_ERR pulse, no ALU_EN. Then CC,1,2,0x13 -> FRAME_ERR pulse, no ALU_EN, ALU_FUN unchanged.
- CC,0x05, then TIMEOUT_CYC idle cycles -> FRAME_ERR exactly TIMEOUT_CYC cycles after the last byte. A following complete frame executes normally.
- TX_BUSY held high for 20 cycles after the LSB strobe -> MSB strobe appears only after TX_BUSY falls. An RX byte during that wait gives a FRAME_ERR pulse and the TX sequence completes intact.
- RST low asserted between the LSB and MSB strobes -> all outputs 0 immediately, no MSB strobe, and the next frame works from IDLE.
